// File: rtl/runner_session_monitor.sv
// runner_session_monitor
//   Tracks one running session: session FSM (IDLE/RUN/PAUSE/DONE), saturating
//   step/distance/calorie/time accumulators, peak and moving-average heart
//   rate, per-sample heart-rate class, and a latched emergency alarm.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, pause, stop       session commands (stop > pause > start)
//   sample_valid/ready       sample handshake, ready only while RUN
//   hr_in, steps_in, stride_in  per-sample heart rate, steps, stride
//   alarm_ack                clears alarm unless the last sample was emergency
//   state                    session state
//   total_steps/distance/calories, time_elapsed  saturating accumulators
//   max_hr, avg_hr, avg_valid, hr_class, intensity  heart-rate outputs
//   alarm, sat               latched emergency, sticky saturation flag
module runner_session_monitor #(
   parameter int HR_W       = 8,
   parameter int ACC_W      = 32,
   parameter int LOG2_WIN   = 2,
   parameter int WARN_HR    = 150,
   parameter int EMERG_HR   = 180,
   parameter int CAL_FACTOR = 50,
   parameter int ALARM_CNT  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [HR_W-1:0]   hr_in,
   input  logic [1:0]        steps_in,
   input  logic [7:0]        stride_in,
   input  logic              alarm_ack,
   output logic [1:0]        state,
   output logic [15:0]       total_steps,
   output logic [ACC_W-1:0]  total_distance,
   output logic [ACC_W-1:0]  total_calories,
   output logic [15:0]       time_elapsed,
   output logic [HR_W-1:0]   max_hr,
   output logic [HR_W-1:0]   avg_hr,
   output logic              avg_valid,
   output logic [1:0]        hr_class,
   output logic [1:0]        intensity,
   output logic              alarm,
   output logic              sat
);

   localparam int WIN   = 1 << LOG2_WIN;
   localparam int SW    = HR_W + LOG2_WIN;
   localparam int CNT_W = $clog2(ALARM_CNT + 1);
   // wide enough for ACC_W + 10-bit distance * 32-bit factor without wrap
   localparam int CW    = ACC_W + 43;
   localparam int DW    = ACC_W + 11;

   localparam logic [HR_W-1:0]     WARN_V  = HR_W'(WARN_HR);
   localparam logic [HR_W-1:0]     EMERG_V = HR_W'(EMERG_HR);
   localparam logic [HR_W-1:0]     INT_LO  = HR_W'(120);
   localparam logic [HR_W-1:0]     INT_HI  = HR_W'(160);
   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(ALARM_CNT);
   localparam logic [LOG2_WIN:0]   WIN_V   = (LOG2_WIN + 1)'(WIN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t               state_q, state_d;
   logic [15:0]          steps_q, steps_d;
   logic [ACC_W-1:0]     dist_q, dist_d;
   logic [ACC_W-1:0]     cal_q, cal_d;
   logic [15:0]          time_q, time_d;
   logic [HR_W-1:0]      max_q, max_d;
   logic [HR_W-1:0]      win_q [WIN];
   logic [HR_W-1:0]      win_d [WIN];
   logic [LOG2_WIN-1:0]  wptr_q, wptr_d;
   logic [LOG2_WIN:0]    fill_q, fill_d;
   logic [SW-1:0]        sum_q, sum_d;
   logic [1:0]           cls_q, cls_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 alarm_q, alarm_d;
   logic                 sat_q, sat_d;

   logic                 accept, clr, emerg;
   logic [9:0]           d;
   logic [16:0]          steps_sum, time_sum;
   logic [DW-1:0]        dist_sum;
   logic [CW-1:0]        cal_sum;
   logic                 steps_ovf, time_ovf, dist_ovf, cal_ovf;

   assign accept    = sample_valid && (state_q == S_RUN);
   // A fresh session starts whenever RUN is entered from IDLE or DONE
   assign clr       = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign emerg     = hr_in > EMERG_V;

   assign d         = 10'(steps_in) * 10'(stride_in);
   assign steps_sum = {1'b0, steps_q} + 17'(steps_in);
   assign time_sum  = {1'b0, time_q} + 17'd1;
   assign dist_sum  = DW'(dist_q) + DW'(d);
   assign cal_sum   = CW'(cal_q) + CW'(d) * CW'($unsigned(CAL_FACTOR));
   assign steps_ovf = steps_sum[16];
   assign time_ovf  = time_sum[16];
   assign dist_ovf  = |dist_sum[DW-1:ACC_W];
   assign cal_ovf   = |cal_sum[CW-1:ACC_W];

   always_comb begin
      state_d = state_q;
      steps_d = steps_q;
      dist_d  = dist_q;
      cal_d   = cal_q;
      time_d  = time_q;
      max_d   = max_q;
      win_d   = win_q;
      wptr_d  = wptr_q;
      fill_d  = fill_q;
      sum_d   = sum_q;
      cls_d   = cls_q;
      cnt_d   = cnt_q;
      alarm_d = alarm_q;
      sat_d   = sat_q;

      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (stop) state_d = S_DONE;
                  else if (pause) state_d = S_PAUSE;
         S_PAUSE: if (stop) state_d = S_DONE;
                  else if (start) state_d = S_RUN;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase

      // ack only counts once the latest sample is out of the emergency band
      if (alarm_ack && (cls_q != 2'b10)) alarm_d = 1'b0;

      if (accept) begin
         steps_d = steps_ovf ? '1 : steps_sum[15:0];
         time_d  = time_ovf  ? '1 : time_sum[15:0];
         dist_d  = dist_ovf  ? '1 : dist_sum[ACC_W-1:0];
         cal_d   = cal_ovf   ? '1 : cal_sum[ACC_W-1:0];
         if (steps_ovf || time_ovf || dist_ovf || cal_ovf) sat_d = 1'b1;

         if (hr_in > max_q) max_d = hr_in;

         // Window slots start at zero, so subtracting the oldest slot is
         // correct while the window is still filling.
         sum_d         = sum_q - SW'(win_q[wptr_q]) + SW'(hr_in);
         win_d[wptr_q] = hr_in;
         wptr_d        = wptr_q + 1'b1;
         if (fill_q != WIN_V) fill_d = fill_q + 1'b1;

         if (hr_in <= WARN_V)       cls_d = 2'b00;
         else if (hr_in <= EMERG_V) cls_d = 2'b01;
         else                       cls_d = 2'b10;

         if (emerg) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
         else       cnt_d = '0;

         // set overrides a same-cycle ack
         if (emerg && (cnt_d == CNT_MAX)) alarm_d = 1'b1;
      end

      if (clr) begin
         steps_d = '0;
         dist_d  = '0;
         cal_d   = '0;
         time_d  = '0;
         max_d   = '0;
         for (int i = 0; i < WIN; i++) win_d[i] = '0;
         wptr_d  = '0;
         fill_d  = '0;
         sum_d   = '0;
         cnt_d   = '0;
         alarm_d = 1'b0;
         sat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         steps_q <= '0;
         dist_q  <= '0;
         cal_q   <= '0;
         time_q  <= '0;
         max_q   <= '0;
         for (int i = 0; i < WIN; i++) win_q[i] <= '0;
         wptr_q  <= '0;
         fill_q  <= '0;
         sum_q   <= '0;
         cls_q   <= '0;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         steps_q <= steps_d;
         dist_q  <= dist_d;
         cal_q   <= cal_d;
         time_q  <= time_d;
         max_q   <= max_d;
         win_q   <= win_d;
         wptr_q  <= wptr_d;
         fill_q  <= fill_d;
         sum_q   <= sum_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
         sat_q   <= sat_d;
      end
   end

   assign sample_ready   = (state_q == S_RUN);
   assign state          = state_q;
   assign total_steps    = steps_q;
   assign total_distance = dist_q;
   assign total_calories = cal_q;
   assign time_elapsed   = time_q;
   assign max_hr         = max_q;
   assign avg_valid      = (fill_q == WIN_V);
   assign avg_hr         = avg_valid ? sum_q[SW-1:LOG2_WIN] : '0;
   assign hr_class       = cls_q;
   assign alarm          = alarm_q;
   assign sat            = sat_q;

   always_comb begin
      intensity = 2'b00;
      if (avg_valid) begin
         if (avg_hr < INT_LO)       intensity = 2'b00;
         else if (avg_hr <= INT_HI) intensity = 2'b01;
         else                       intensity = 2'b10;
      end
   end

endmodule

// File: tb/tb_runner_session_monitor.sv
// Directed bench for runner_session_monitor (ACC_W = 16 so saturation is
// reachable quickly; all other parameters at default).
module tb_runner_session_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [7:0]  hr_in = '0;
   logic [1:0]  steps_in = '0;
   logic [7:0]  stride_in = '0;
   logic        alarm_ack = 1'b0;
   logic [1:0]  state;
   logic [15:0] total_steps;
   logic [15:0] total_distance;
   logic [15:0] total_calories;
   logic [15:0] time_elapsed;
   logic [7:0]  max_hr;
   logic [7:0]  avg_hr;
   logic        avg_valid;
   logic [1:0]  hr_class;
   logic [1:0]  intensity;
   logic        alarm;
   logic        sat;

   int n_chk = 0;
   int n_err = 0;

   runner_session_monitor #(.ACC_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .hr_in(hr_in), .steps_in(steps_in), .stride_in(stride_in),
      .alarm_ack(alarm_ack), .state(state), .total_steps(total_steps),
      .total_distance(total_distance), .total_calories(total_calories),
      .time_elapsed(time_elapsed), .max_hr(max_hr), .avg_hr(avg_hr),
      .avg_valid(avg_valid), .hr_class(hr_class), .intensity(intensity),
      .alarm(alarm), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one clock; outputs sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd_start(); start = 1'b1; step(); start = 1'b0; endtask
   task automatic cmd_stop();  stop  = 1'b1; step(); stop  = 1'b0; endtask

   task automatic send(input logic [7:0] hr, input logic [1:0] st, input logic [7:0] sd);
      hr_in = hr; steps_in = st; stride_in = sd; sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
   endtask

   initial begin
      // reset
      step(); step();
      rst = 1'b0;
      chk("rst_state", state, 0);
      chk("rst_ready", sample_ready, 0);
      chk("rst_steps", total_steps, 0);
      chk("rst_alarm", alarm, 0);

      // basic session
      cmd_start();
      chk("run_state", state, 1);
      chk("run_ready", sample_ready, 1);
      for (int i = 0; i < 3; i++) send(8'd100, 2'd2, 8'd50);
      chk("win3_valid", avg_valid, 0);
      chk("win3_avg", avg_hr, 0);
      send(8'd100, 2'd2, 8'd50);
      chk("b_steps", total_steps, 8);
      chk("b_dist", total_distance, 400);
      chk("b_cal", total_calories, 20000);
      chk("b_time", time_elapsed, 4);
      chk("b_avg", avg_hr, 100);
      chk("b_avgv", avg_valid, 1);
      chk("b_int", intensity, 0);
      chk("b_max", max_hr, 100);

      // pause coinciding with an accepted sample, then held valid
      hr_in = 8'd100; steps_in = 2'd2; stride_in = 8'd50;
      sample_valid = 1'b1; pause = 1'b1;
      step();
      pause = 1'b0;
      chk("p_state", state, 2);
      chk("p_time", time_elapsed, 5);
      chk("p_ready", sample_ready, 0);
      step(); step(); step();
      sample_valid = 1'b0;
      chk("p_frz_time", time_elapsed, 5);
      chk("p_frz_steps", total_steps, 10);
      cmd_start();
      chk("resume_state", state, 1);
      chk("resume_steps", total_steps, 10);
      cmd_stop();
      chk("done_state", state, 3);
      chk("done_ready", sample_ready, 0);
      cmd_start();
      chk("clr_steps", total_steps, 0);
      chk("clr_time", time_elapsed, 0);
      chk("clr_cal", total_calories, 0);
      chk("clr_avgv", avg_valid, 0);

      // moving window
      send(8'd120, 2'd0, 8'd0);
      send(8'd160, 2'd0, 8'd0);
      send(8'd200, 2'd0, 8'd0);
      chk("w_cls_emerg", hr_class, 2);
      send(8'd120, 2'd0, 8'd0);
      chk("w_avg4", avg_hr, 150);
      chk("w_int4", intensity, 1);
      chk("w_max", max_hr, 200);
      chk("w_cls_warn", hr_class, 0);
      send(8'd80, 2'd0, 8'd0);
      chk("w_avg5", avg_hr, 140);
      chk("w_int5", intensity, 1);

      // alarm
      cmd_stop(); cmd_start();
      send(8'd185, 2'd0, 8'd0);
      send(8'd190, 2'd0, 8'd0);
      chk("a_pre", alarm, 0);
      send(8'd181, 2'd0, 8'd0);
      chk("a_set", alarm, 1);
      chk("a_cls", hr_class, 2);
      alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
      chk("a_ack_ign", alarm, 1);
      send(8'd140, 2'd0, 8'd0);
      chk("a_hold", alarm, 1);
      chk("a_cls140", hr_class, 0);
      alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
      chk("a_clr", alarm, 0);

      // saturation: d = 765, calories step = 38250
      cmd_stop(); cmd_start();
      send(8'd100, 2'd3, 8'd255);
      chk("s_cal1", total_calories, 38250);
      chk("s_sat1", sat, 0);
      send(8'd100, 2'd3, 8'd255);
      chk("s_cal2", total_calories, 65535);
      chk("s_sat2", sat, 1);
      send(8'd100, 2'd3, 8'd255);
      chk("s_cal3", total_calories, 65535);
      chk("s_dist3", total_distance, 2295);
      chk("s_steps3", total_steps, 9);

      // alarm set with same-cycle ack, then reset mid-run
      send(8'd185, 2'd0, 8'd0);
      send(8'd190, 2'd0, 8'd0);
      alarm_ack = 1'b1;
      send(8'd181, 2'd0, 8'd0);
      alarm_ack = 1'b0;
      chk("a_setwins", alarm, 1);
      rst = 1'b1; start = 1'b1; sample_valid = 1'b1;
      step();
      rst = 1'b0; start = 1'b0; sample_valid = 1'b0;
      chk("r_state", state, 0);
      chk("r_ready", sample_ready, 0);
      chk("r_alarm", alarm, 0);
      chk("r_sat", sat, 0);
      chk("r_cal", total_calories, 0);
      chk("r_dist", total_distance, 0);
      chk("r_steps", total_steps, 0);
      chk("r_time", time_elapsed, 0);
      chk("r_max", max_hr, 0);
      chk("r_cls", hr_class, 0);
      chk("r_avgv", avg_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
